// File: rtl/switch_pkg.sv
// ============================================================================
// Module   : switch_pkg
// Purpose  : Shared definitions for the 2x2 switch port transmitter: default
//            word width, header field layout and transmitter FSM states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package switch_pkg;

    // Default width of one packet word (matches switch inData).
    localparam int DATA_W_DEFAULT = 32;

    // Header word layout: destination port lives in the low byte.
    localparam int DEST_LSB = 0;
    localparam int DEST_W   = 8;

    // Transmitter states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/switch_port_tx_if.sv
// ============================================================================
// Module   : switch_port_tx_if
// Purpose  : Valid/ready word write bus feeding the port transmitter.
// Ports    : wr_valid - word valid         (master -> slave)
//            wr_data  - packet word        (master -> slave)
//            wr_last  - final word marker  (master -> slave)
//            wr_ready - word accepted      (slave  -> master)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface switch_port_tx_if
    import switch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              wr_ready;

    modport master (
        output wr_valid,
        output wr_data,
        output wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  wr_last,
        output wr_ready
    );
endinterface

`default_nettype wire

// File: rtl/switch_port_tx_fifo.sv
// ============================================================================
// Module   : tx_word_fifo
// Purpose  : Synchronous first-word-fall-through FIFO holding {last, data}.
// Ports    : clk, rst            - clock, async active-high reset
//            push, push_data     - write strobe / word (ignored when full)
//            pop, pop_data       - read strobe (ignored when empty) / head word
//            full, empty, count  - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_word_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count    = wr_ptr_q - rd_ptr_q;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end
endmodule

`default_nettype wire

// File: rtl/switch_port_tx.sv
// ============================================================================
// Module   : switch_port_tx
// Purpose  : Store-and-forward packet transmitter for one switch port.
//            Buffers words from the write bus and replays each complete
//            packet to the switch as a contiguous sop..eop burst.
// Ports    : clk, rst   - clock, async active-high reset
//            wr         - valid/ready word write bus (slave side)
//            stall      - switch portStall, blocks starting a new packet
//            out_data/out_sop/out_eop - to switch inData/insop/ineop
//            pkt_cnt    - complete packets currently buffered
//            trunc_err  - one-cycle pulse on oversized-packet truncation
//            busy       - high while sending or in the inter-packet gap
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_port_tx
    import switch_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEFAULT,
    parameter int FIFO_DEPTH    = 64,
    parameter int MAX_PKT_WORDS = 32,
    parameter int IPG_CYCLES    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    switch_port_tx_if.slave               wr,
    input  logic                          stall,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic [$clog2(FIFO_DEPTH):0]   pkt_cnt,
    output logic                          trunc_err,
    output logic                          busy
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IN_W  = $clog2(MAX_PKT_WORDS + 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SEND = SEND;
    localparam logic [1:0] ST_GAP  = GAP;

    // After the eop word is popped: with no gap requested the FSM is idle in
    // the eop cycle itself, otherwise GAP covers exactly IPG_CYCLES cycles.
    localparam logic [1:0] ST_AFTER_EOP = (IPG_CYCLES == 0) ? ST_IDLE : ST_GAP;
    localparam logic [3:0] GAP_LOAD     = (IPG_CYCLES > 0) ? 4'(IPG_CYCLES - 1) : 4'd0;

    logic [1:0]        state_q, state_d;
    logic [3:0]        gap_q, gap_d;
    logic [IN_W-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic              trunc_q, trunc_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W:0]   fifo_head;
    logic              fifo_pop;
    logic              accept;
    logic              at_limit;
    logic              push_last;
    logic              head_last;
    logic              pkt_in;
    logic              pkt_out;

    tx_word_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data ({push_last, wr.wr_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign wr.wr_ready = !fifo_full;
    assign head_last   = fifo_head[DATA_W];

    // Input side: word counting and forced termination of oversized packets.
    always_comb begin
        accept    = wr.wr_valid && !fifo_full;
        at_limit  = (in_cnt_q == IN_W'(MAX_PKT_WORDS - 1));
        push_last = wr.wr_last || at_limit;
        trunc_d   = accept && at_limit && !wr.wr_last;
        in_cnt_d  = in_cnt_q;
        if (accept) begin
            in_cnt_d = push_last ? '0 : in_cnt_q + IN_W'(1);
        end
    end

    // Output side FSM. stall only gates the launch decision in IDLE.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        fifo_pop = 1'b0;
        sop_d    = 1'b0;
        eop_d    = 1'b0;
        data_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if ((pkt_cnt_q != '0) && (fifo_count != '0) && !stall) begin
                    fifo_pop = 1'b1;
                    sop_d    = 1'b1;
                    eop_d    = head_last;
                    data_d   = fifo_head[DATA_W-1:0];
                    state_d  = head_last ? ST_AFTER_EOP : ST_SEND;
                    gap_d    = GAP_LOAD;
                end
            end
            ST_SEND: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    eop_d    = head_last;
                    data_d   = fifo_head[DATA_W-1:0];
                    if (head_last) begin
                        state_d = ST_AFTER_EOP;
                        gap_d   = GAP_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Packet count: a packet enters when its last word is written and leaves
    // on the edge that registers its eop.
    always_comb begin
        pkt_in    = accept && push_last;
        pkt_out   = fifo_pop && head_last;
        pkt_cnt_d = pkt_cnt_q;
        if (pkt_in && !pkt_out && (pkt_cnt_q != CNT_W'(FIFO_DEPTH))) begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end else if (pkt_out && !pkt_in && (pkt_cnt_q != '0)) begin
            pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gap_q     <= 4'd0;
            in_cnt_q  <= '0;
            pkt_cnt_q <= '0;
            data_q    <= '0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            trunc_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            in_cnt_q  <= in_cnt_d;
            pkt_cnt_q <= pkt_cnt_d;
            data_q    <= data_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            trunc_q   <= trunc_d;
        end
    end

    assign out_data  = data_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign trunc_err = trunc_q;
    assign busy      = (state_q == ST_SEND) || (state_q == ST_GAP);
endmodule

`default_nettype wire

// File: tb/tb_switch_port_tx.sv
// ============================================================================
// Module   : tb_switch_port_tx
// Purpose  : Self-checking bench for switch_port_tx with a packet-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_port_tx;
    import switch_pkg::*;

    localparam int DW    = DATA_W_DEFAULT;
    localparam int DEPTH = 64;
    localparam int MAXW  = 32;
    localparam int IPG   = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          stall;
    logic [DW-1:0] out_data;
    logic          out_sop;
    logic          out_eop;
    logic [CW-1:0] pkt_cnt;
    logic          trunc_err;
    logic          busy;

    switch_port_tx_if #(.DATA_W(DW)) wr_if ();

    switch_port_tx #(
        .DATA_W        (DW),
        .FIFO_DEPTH    (DEPTH),
        .MAX_PKT_WORDS (MAXW),
        .IPG_CYCLES    (IPG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr        (wr_if),
        .stall     (stall),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .pkt_cnt   (pkt_cnt),
        .trunc_err (trunc_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- output monitor: rebuilds packets ----------------
    logic [DW:0] rx_w[$];       // {eop, data} of every word inside a packet
    int          rx_sop[$];     // cycle stamp of each sop
    int          rx_eop[$];     // cycle stamp of each eop
    int          rx_eop_pc[$];  // pkt_cnt seen in each eop cycle
    int          trunc_cnt = 0;
    int          stray     = 0;
    int          proto_err = 0;
    bit          in_pkt    = 1'b0;

    always @(posedge rst) in_pkt = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            in_pkt = 1'b0;
        end else begin
            if (out_sop) begin
                if (in_pkt) proto_err++;
                in_pkt = 1'b1;
                rx_sop.push_back(cyc);
            end
            if (in_pkt) begin
                rx_w.push_back({out_eop, out_data});
                if (out_eop) begin
                    in_pkt = 1'b0;
                    rx_eop.push_back(cyc);
                    rx_eop_pc.push_back(int'(pkt_cnt));
                end
            end else if (out_eop || (out_data != '0)) begin
                stray++;
            end
            if (trunc_err) trunc_cnt++;
        end
    end

    // ---------------- reference model ----------------
    // Expected output stream: words in order, a packet ends on the writer's
    // last flag or when it reaches MAXW words.
    logic [DW:0] exp_w[$];
    int          mcnt = 0;

    function automatic void model_add(input logic [DW-1:0] d, input bit l);
        bit e;
        mcnt++;
        e = l || (mcnt == MAXW);
        exp_w.push_back({e, d});
        if (e) mcnt = 0;
    endfunction

    // ---------------- drivers ----------------
    // Called just after a negedge; returns at the negedge after acceptance.
    task automatic put_word(input logic [DW-1:0] d, input bit l);
        int t;
        t = 0;
        model_add(d, l);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = d;
        wr_if.wr_last  = l;
        while (!wr_if.wr_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL put_word: wr_ready stuck low, got 0 required 1");
        end
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
        wr_if.wr_last  = 1'b0;
        wr_if.wr_data  = '0;
    endtask

    task automatic wait_rx(input int target, output bit ok);
        int t;
        t = 0;
        while (rx_w.size() < target && t < 600) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        ok = (rx_w.size() >= target);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp += 7;
        if (out_sop !== 1'b0)      begin n_bad++; $display("FAIL reset_sop: got %b required 0", out_sop); end
        if (out_eop !== 1'b0)      begin n_bad++; $display("FAIL reset_eop: got %b required 0", out_eop); end
        if (out_data !== '0)       begin n_bad++; $display("FAIL reset_data: got %h required 0", out_data); end
        if (pkt_cnt !== '0)        begin n_bad++; $display("FAIL reset_pkt_cnt: got %0d required 0", pkt_cnt); end
        if (trunc_err !== 1'b0)    begin n_bad++; $display("FAIL reset_trunc: got %b required 0", trunc_err); end
        if (busy !== 1'b0)         begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (wr_if.wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b required 1", wr_if.wr_ready); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_four_word();
        int base, s0, e0, acc;
        bit ok;
        exp_w.delete();
        base = rx_w.size(); s0 = rx_sop.size(); e0 = rx_eop.size();
        put_word(32'h0000_0001, 1'b0);
        put_word(32'h0000_00A1, 1'b0);
        put_word(32'h0000_00A2, 1'b0);
        put_word(32'h0000_00A3, 1'b1);
        acc = cyc;
        n_cmp++;
        if (pkt_cnt !== CW'(1)) begin n_bad++; $display("FAIL four_cnt_in: got %0d required 1", pkt_cnt); end
        wait_rx(base + 4, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL four_timeout: got %0d words required 4", rx_w.size() - base); end
        else begin
            n_cmp += 3;
            if (rx_sop[s0] != acc + 1) begin n_bad++; $display("FAIL four_latency: got sop cyc %0d required %0d", rx_sop[s0], acc + 1); end
            if (rx_eop[e0] != rx_sop[s0] + 3) begin n_bad++; $display("FAIL four_len: got eop cyc %0d required %0d", rx_eop[e0], rx_sop[s0] + 3); end
            if (rx_eop_pc[e0] != 0) begin n_bad++; $display("FAIL four_cnt_out: got %0d required 0", rx_eop_pc[e0]); end
            for (int k = 0; k < exp_w.size(); k++) begin
                n_cmp++;
                if (rx_w[base + k] !== exp_w[k]) begin
                    n_bad++; $display("FAIL four_word%0d: got %h required %h", k, rx_w[base + k], exp_w[k]);
                end
            end
        end
    endtask

    task automatic test_single();
        int base, s0, e0, acc;
        bit ok;
        repeat (5) @(negedge clk);
        exp_w.delete();
        base = rx_w.size(); s0 = rx_sop.size(); e0 = rx_eop.size();
        put_word(32'h0000_0002, 1'b1);
        acc = cyc;
        wait_rx(base + 1, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL single_timeout: got 0 words required 1"); end
        else begin
            n_cmp += 3;
            if (rx_sop[s0] != acc + 1) begin n_bad++; $display("FAIL single_latency: got %0d required %0d", rx_sop[s0], acc + 1); end
            if (rx_eop[e0] != rx_sop[s0]) begin n_bad++; $display("FAIL single_sop_eop: got eop cyc %0d required %0d", rx_eop[e0], rx_sop[s0]); end
            if (rx_w[base] !== exp_w[0]) begin n_bad++; $display("FAIL single_word: got %h required %h", rx_w[base], exp_w[0]); end
        end
    endtask

    task automatic test_back_to_back();
        int base, s0, e0;
        bit ok;
        repeat (5) @(negedge clk);
        exp_w.delete();
        base = rx_w.size(); s0 = rx_sop.size(); e0 = rx_eop.size();
        stall = 1'b1;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 3; i++)
                put_word($urandom, i == 2);
        n_cmp++;
        if (pkt_cnt !== CW'(2)) begin n_bad++; $display("FAIL b2b_cnt: got %0d required 2", pkt_cnt); end
        stall = 1'b0;
        wait_rx(base + 6, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL b2b_timeout: got %0d words required 6", rx_w.size() - base); end
        else begin
            n_cmp += 3;
            if (rx_sop[s0 + 1] != rx_eop[e0] + IPG + 1) begin
                n_bad++; $display("FAIL b2b_gap: got sop cyc %0d required %0d", rx_sop[s0 + 1], rx_eop[e0] + IPG + 1);
            end
            if (rx_eop_pc[e0] != 1) begin n_bad++; $display("FAIL b2b_cnt1: got %0d required 1", rx_eop_pc[e0]); end
            if (rx_eop_pc[e0 + 1] != 0) begin n_bad++; $display("FAIL b2b_cnt0: got %0d required 0", rx_eop_pc[e0 + 1]); end
            for (int k = 0; k < exp_w.size(); k++) begin
                n_cmp++;
                if (rx_w[base + k] !== exp_w[k]) begin
                    n_bad++; $display("FAIL b2b_word%0d: got %h required %h", k, rx_w[base + k], exp_w[k]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int base, s0, c0;
        bit ok;
        repeat (5) @(negedge clk);
        exp_w.delete();
        base = rx_w.size(); s0 = rx_sop.size();
        stall = 1'b1;
        put_word(32'h0000_0003, 1'b0);
        put_word($urandom, 1'b1);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (out_sop !== 1'b0) begin n_bad++; $display("FAIL stall_hold%0d: got sop %b required 0", i, out_sop); end
            @(negedge clk);
        end
        stall = 1'b0;
        c0 = cyc;
        wait_rx(base + 2, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL stall_timeout: got %0d words required 2", rx_w.size() - base); end
        else begin
            n_cmp++;
            if (rx_sop[s0] != c0 + 1) begin n_bad++; $display("FAIL stall_release: got sop cyc %0d required %0d", rx_sop[s0], c0 + 1); end
            for (int k = 0; k < exp_w.size(); k++) begin
                n_cmp++;
                if (rx_w[base + k] !== exp_w[k]) begin
                    n_bad++; $display("FAIL stall_word%0d: got %h required %h", k, rx_w[base + k], exp_w[k]);
                end
            end
        end
    endtask

    task automatic test_stall_mid();
        int base, s0, e0, t;
        bit ok;
        repeat (5) @(negedge clk);
        exp_w.delete();
        base = rx_w.size(); s0 = rx_sop.size(); e0 = rx_eop.size();
        for (int i = 0; i < 5; i++) put_word(32'h5000_0000 + i, i == 4);
        t = 0;
        while (!out_sop && t < 20) begin @(negedge clk); t++; end
        stall = 1'b1;
        wait_rx(base + 5, ok);
        stall = 1'b0;
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL stallmid_timeout: got %0d words required 5", rx_w.size() - base); end
        else begin
            n_cmp++;
            if (rx_eop[e0] != rx_sop[s0] + 4) begin n_bad++; $display("FAIL stallmid_contig: got eop cyc %0d required %0d", rx_eop[e0], rx_sop[s0] + 4); end
            for (int k = 0; k < exp_w.size(); k++) begin
                n_cmp++;
                if (rx_w[base + k] !== exp_w[k]) begin
                    n_bad++; $display("FAIL stallmid_word%0d: got %h required %h", k, rx_w[base + k], exp_w[k]);
                end
            end
        end
    endtask

    task automatic test_trunc();
        int base, e0, tc0;
        bit ok;
        repeat (5) @(negedge clk);
        exp_w.delete();
        base = rx_w.size(); e0 = rx_eop.size(); tc0 = trunc_cnt;
        for (int i = 0; i < 40; i++) begin
            put_word(32'h0000_0100 + i, i == 39);
            if (i == MAXW - 1) begin
                n_cmp++;
                if (trunc_err !== 1'b1) begin n_bad++; $display("FAIL trunc_pulse: got %b required 1", trunc_err); end
            end
        end
        wait_rx(base + 40, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL trunc_timeout: got %0d words required 40", rx_w.size() - base); end
        else begin
            n_cmp += 2;
            if (trunc_cnt - tc0 != 1) begin n_bad++; $display("FAIL trunc_count: got %0d pulses required 1", trunc_cnt - tc0); end
            if (rx_eop.size() - e0 != 2) begin n_bad++; $display("FAIL trunc_pkts: got %0d packets required 2", rx_eop.size() - e0); end
            for (int k = 0; k < exp_w.size(); k++) begin
                n_cmp++;
                if (rx_w[base + k] !== exp_w[k]) begin
                    n_bad++; $display("FAIL trunc_word%0d: got %h required %h", k, rx_w[base + k], exp_w[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        int base, s0, e0, total, len;
        logic [DW-1:0] hdr;
        bit ok;
        repeat (5) @(negedge clk);
        exp_w.delete();
        base = rx_w.size(); s0 = rx_sop.size(); e0 = rx_eop.size();
        total = 0;
        for (int p = 0; p < 8; p++) begin
            stall = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            stall = 1'b0;
            len = $urandom_range(1, 12);
            hdr = $urandom;
            hdr[DEST_LSB +: DEST_W] = DEST_W'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                put_word((i == 0) ? hdr : DW'($urandom), i == len - 1);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            total += len;
        end
        wait_rx(base + total, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL rand_timeout: got %0d words required %0d", rx_w.size() - base, total); end
        else begin
            for (int k = 0; k < exp_w.size(); k++) begin
                n_cmp++;
                if (rx_w[base + k] !== exp_w[k]) begin
                    n_bad++; $display("FAIL rand_word%0d: got %h required %h", k, rx_w[base + k], exp_w[k]);
                end
            end
            for (int i = 0; i < 7; i++) begin
                n_cmp++;
                if (rx_sop[s0 + i + 1] - rx_eop[e0 + i] < IPG + 1) begin
                    n_bad++; $display("FAIL rand_ipg%0d: got gap %0d required >= %0d", i, rx_sop[s0 + i + 1] - rx_eop[e0 + i], IPG + 1);
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        int t, sops;
        logic [DW-1:0] w [8];
        repeat (5) @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w[i] = 32'hC000_0000 + i + 1;
            put_word(w[i], i == 7);
        end
        put_word(32'h0000_0009, 1'b0);
        put_word(32'h0000_000A, 1'b1);
        stall = 1'b0;
        t = 0;
        while (!out_sop && t < 20) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_data !== w[2]) begin n_bad++; $display("FAIL rst_pre_data: got %h required %h", out_data, w[2]); end
        #2 rst = 1'b1;
        #1;
        n_cmp += 6;
        if (out_sop !== 1'b0)   begin n_bad++; $display("FAIL rst_sop: got %b required 0", out_sop); end
        if (out_eop !== 1'b0)   begin n_bad++; $display("FAIL rst_eop: got %b required 0", out_eop); end
        if (out_data !== '0)    begin n_bad++; $display("FAIL rst_data: got %h required 0", out_data); end
        if (pkt_cnt !== '0)     begin n_bad++; $display("FAIL rst_pkt_cnt: got %0d required 0", pkt_cnt); end
        if (wr_if.wr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b required 1", wr_if.wr_ready); end
        if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %b required 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        mcnt = 0;
        sops = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_sop) sops++;
        end
        n_cmp++;
        if (sops != 0) begin n_bad++; $display("FAIL rst_discard: got %0d sops required 0", sops); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;
        wr_if.wr_last  = 1'b0;
        test_reset();
        test_four_word();
        test_single();
        test_back_to_back();
        test_stall();
        test_stall_mid();
        test_trunc();
        test_random();
        test_rst_mid();
        n_cmp += 2;
        if (stray != 0)     begin n_bad++; $display("FAIL idle_outputs: got %0d stray cycles required 0", stray); end
        if (proto_err != 0) begin n_bad++; $display("FAIL sop_nesting: got %0d errors required 0", proto_err); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/switch_port_tx.md
Name: switch_port_tx

Overview:
- Ingress-side packet transmitter for one port of the 2x2 switch. It is the sending end of the sop/eop word protocol that the switch consumes on inData/insop/ineop.
- Accepts packet words on a simple valid/ready write interface and buffers them store-and-forward.
- Replays each complete packet onto the switch input as a contiguous sop..eop burst, honouring the switch's portStall between packets.
- One instance per switch port (A, B).

Parameters:
- DATA_W, 32, width of one packet word; matches switch inData.
- FIFO_DEPTH, 64, buffered words; must be a power of two and >= MAX_PKT_WORDS.
- MAX_PKT_WORDS, 32, longest legal packet; longer input is truncated.
- IPG_CYCLES, 1, minimum idle cycles between one eop and the next sop (range 0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  write word valid.
- wr_data  in  DATA_W  packet word; the first word of a packet is the header, with destination in bits [7:0].
- wr_last  in  1  marks the final word of the packet.
- wr_ready  out  1  buffer can accept a word.
- stall  in  1  switch portStall for this port; blocks starting a new packet.
- out_data  out  DATA_W  to switch inData.
- out_sop  out  1  to switch insop.
- out_eop  out  1  to switch ineop.
- pkt_cnt  out  $clog2(FIFO_DEPTH)+1  complete packets buffered.
- trunc_err  out  1  one-cycle pulse when an oversized packet is truncated.
- busy  out  1  high in SEND or GAP.

Behaviour:
- Reset (async assert, sync release): FIFO empty, pkt_cnt=0, state IDLE, all outputs 0 except wr_ready=1.
- Write acceptance:
  - A word is accepted when wr_valid && wr_ready.
  - wr_ready = !fifo_full.
  - FIFO stores {last, data}.
- Input word counter and truncation:
  - An internal word counter tracks words in the current input packet.
  - If the counter reaches MAX_PKT_WORDS without wr_last, that word is stored with last=1 and trunc_err pulses in the following cycle.
  - Subsequent words up to the real wr_last form a new packet; the bench treats them as garbage.
- pkt_cnt:
  - +1 on the edge after a last-marked word is accepted.
  - -1 on the edge where eop is driven.
  - Both in the same cycle leaves it unchanged; it never wraps.
- FSM states: IDLE, SEND, GAP.
  - IDLE: if pkt_cnt>0 && !stall, pop the head word and register out_sop=1, out_data=word, out_eop=word.last. Go to SEND, or to GAP if last.
  - SEND: one word per cycle with out_sop=0. The last-marked word sets out_eop=1, then go to GAP.
  - stall is ignored in SEND; a started packet is never interrupted.
  - GAP: hold for IPG_CYCLES cycles with sop=eop=0, then go to IDLE. With IPG_CYCLES=0, go from the eop cycle directly to IDLE.
- The FIFO never underruns in SEND, because the whole packet is already buffered.
- Latency: if the last word is accepted in cycle N with stall=0 and the FSM idle, out_sop is high in cycle N+2.
- Back-to-back packets: the earliest next sop is IPG_CYCLES+1 cycles after eop (IDLE takes one cycle).
- A single-word packet drives sop and eop together in the same cycle.
- out_data is 0 whenever the transmitter is not sending a packet word.
- Simultaneous write and read on a full FIFO: wr_ready is already low, so there is no write that cycle.
- stall rising in the same cycle IDLE would launch a packet: the packet is not launched (stall is sampled combinationally in IDLE).
- rst asserted mid-packet: outputs drop to 0 immediately and buffered data is discarded. The switch sees a missing eop, which is its responsibility.

Decomposition:
- switch_pkg holds:
  - DATA_W default
  - header field constants (DEST_LSB=0, DEST_W=8)
  - tx_state_t enum {IDLE, SEND, GAP}
- One sub-module, tx_word_fifo: a synchronous FIFO of width DATA_W+1 and depth FIFO_DEPTH, with push/pop/full/empty/count.

Test Plan:
- 4-word packet (0x00000001,0xA1,0xA2,0xA3), stall=0 → sop with 0x00000001 at N+2, then 0xA1, 0xA2, then 0xA3 with eop on consecutive cycles; pkt_cnt goes 1→0.
- 1-word packet 0x00000002 → single cycle with sop=eop=1, data 0x00000002.
- Two 3-word packets queued, IPG_CYCLES=2 → second sop exactly 3 cycles after first eop; pkt_cnt goes 2,1,0.
- stall=1 while a packet is buffered for 10 cycles → no sop for those cycles; sop 1 cycle after stall falls.
- stall raised the cycle after sop of a 5-word packet → all 5 words still sent contiguously.
- 40-word input with MAX_PKT_WORDS=32 → trunc_err pulses once; emitted packets have 32 and 8 words.
- rst mid-SEND → out_sop/out_eop/out_data go to 0 asynchronously, pkt_cnt=0, wr_ready=1.
